// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels, two response slots and the shared-ALU port.
// The master side is the environment (requesters plus ALU); the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;

  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;

  logic           rsp0_valid;
  logic           rsp0_ready;
  logic [W-1:0]   rsp0_result;
  logic           rsp0_zero;
  logic           rsp0_err;

  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [W-1:0]   rsp1_result;
  logic           rsp1_zero;
  logic           rsp1_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_zero,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_zero,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op per two cycles.
// Optional ALU_ARB_ILLEGAL_OP_CHK_EN: unknown op codes are issued as add and answered with err=1.
module alu_share_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input logic clk,
  input logic rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_ready;
  logic [1:0]     eligible;
  logic [OPW-1:0] req_op [2];
  logic [W-1:0]   req_a [2];
  logic [W-1:0]   req_b [2];

  logic [1:0]     rsp_valid;
  logic [W-1:0]   rsp_result [2];
  logic [1:0]     rsp_zero;
  logic [1:0]     rsp_err;

  logic           grant;
  logic           accept;
  logic           capture;
  logic           req_illegal;
  logic [OPW-1:0] sel_op;
  logic [OPW-1:0] issue_op;

  logic           last_grant_reg;
  logic           owner_reg;
  logic           illegal_reg;
  logic [OPW-1:0] alu_op_reg;
  logic [W-1:0]   alu_a_reg;
  logic [W-1:0]   alu_b_reg;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready  = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_op[0]  = bus.req0_op;
  assign req_op[1]  = bus.req1_op;
  assign req_a[0]   = bus.req0_a;
  assign req_a[1]   = bus.req1_a;
  assign req_b[0]   = bus.req0_b;
  assign req_b[1]   = bus.req1_b;

  // A requester still holding an unconsumed response is skipped.
  assign eligible = req_valid & ~rsp_valid;

  always_comb begin
    grant = 1'b0;
    if (eligible == 2'b11) begin
      grant = ~last_grant_reg;
    end else if (eligible[1]) begin
      grant = 1'b1;
    end
  end

  assign accept  = |req_ready;
  assign capture = (state_reg == ISSUE);
  assign sel_op  = req_op[grant];

`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  always_comb begin
    req_illegal = 1'b1;
    case (sel_op)
      OPW'(4'b0000), OPW'(4'b0001), OPW'(4'b0010), OPW'(4'b0110): req_illegal = 1'b0;
      default: req_illegal = 1'b1;
    endcase
  end
  assign issue_op = req_illegal ? OPW'(4'b0010) : sel_op;
`else
  assign req_illegal = 1'b0;
  assign issue_op    = sel_op;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      illegal_reg    <= 1'b0;
      alu_op_reg     <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= grant;
        owner_reg      <= grant;
        illegal_reg    <= req_illegal;
        alu_op_reg     <= issue_op;
        alu_a_reg      <= req_a[grant];
        alu_b_reg      <= req_b[grant];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      localparam logic ID = 1'(gi);
      logic         valid_reg;
      logic [W-1:0] result_reg;
      logic         zero_reg;
      logic         err_reg;

      assign req_ready[gi] = (state_reg == IDLE) && (grant == ID) && eligible[gi];

      // Capture has priority; the slot cannot be valid while its own op is in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          result_reg <= '0;
          zero_reg   <= 1'b0;
          err_reg    <= 1'b0;
        end else if (capture && (owner_reg == ID)) begin
          valid_reg  <= 1'b1;
          result_reg <= illegal_reg ? '0 : bus.alu_result;
          zero_reg   <= ~illegal_reg & bus.alu_zero;
          err_reg    <= illegal_reg;
        end else if (valid_reg && rsp_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign rsp_valid[gi]  = valid_reg;
      assign rsp_result[gi] = result_reg;
      assign rsp_zero[gi]   = zero_reg;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
      assign rsp_err[gi]    = err_reg;
`else
      assign rsp_err[gi]    = 1'b0;
`endif
    end
  endgenerate

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.alu_op      = alu_op_reg;
  assign bus.alu_a       = alu_a_reg;
  assign bus.alu_b       = alu_b_reg;
  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp0_result = rsp_result[0];
  assign bus.rsp0_zero   = rsp_zero[0];
  assign bus.rsp0_err    = rsp_err[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp1_result = rsp_result[1];
  assign bus.rsp1_zero   = rsp_zero[1];
  assign bus.rsp1_err    = rsp_err[1];
endmodule
